// File: rtl/vuvmu_ctrl_vec_load_roq.sv
// Load reorder queue: hands out tags in order, captures out-of-order load
// responses, and retires cache lines to the load data queue in tag order.
module vuvmu_ctrl_vec_load_roq #(
    parameter int TAG_SZ  = 8,
    parameter int DATA_SZ = 128
) (
    input  logic               clk,
    input  logic               reset,
    output logic [TAG_SZ-1:0]  roq_deq_tag_bits,
    output logic               roq_deq_tag_val,
    input  logic               roq_deq_tag_rdy,
    input  logic               memresp_val,
    input  logic [TAG_SZ-1:0]  memresp_tag,
    input  logic [DATA_SZ-1:0] memresp_data,
    output logic [DATA_SZ-1:0] ldq_enq_bits,
    output logic               ldq_enq_val,
    input  logic               ldq_enq_rdy,
    output logic [TAG_SZ:0]    roq_count,
    output logic               roq_err
);
    localparam int DEPTH = 1 << TAG_SZ;

    logic [TAG_SZ-1:0]  r_alloc;
    logic [TAG_SZ-1:0]  r_retire;
    logic [TAG_SZ:0]    r_count;
    logic [DEPTH-1:0]   r_valid;
    logic [DATA_SZ-1:0] r_data [DEPTH];
    logic               r_err;

    logic              w_alloc;
    logic              w_retire;
    logic [TAG_SZ-1:0] w_off;
    logic              w_tag_allocd;
    logic              w_resp_ok;
    logic              w_resp_err;

    // Full exactly when the count MSB is set (count can only reach DEPTH).
    assign roq_deq_tag_val  = ~r_count[TAG_SZ];
    assign roq_deq_tag_bits = r_alloc;
    assign ldq_enq_val      = r_valid[r_retire];
    assign ldq_enq_bits     = r_data[r_retire];
    assign roq_count        = r_count;
    assign roq_err          = r_err;

    assign w_alloc      = roq_deq_tag_val & roq_deq_tag_rdy;
    assign w_retire     = ldq_enq_val & ldq_enq_rdy;
    // Distance from the head in modular tag space decides ownership.
    assign w_off        = memresp_tag - r_retire;
    assign w_tag_allocd = {1'b0, w_off} < r_count;
    // A valid entry (including the head being retired) rejects a response.
    assign w_resp_ok    = memresp_val & w_tag_allocd & ~r_valid[memresp_tag];
    assign w_resp_err   = memresp_val & ~w_resp_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alloc  <= '0;
            r_retire <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_alloc)
                r_alloc <= r_alloc + TAG_SZ'(1);
            if (w_retire) begin
                r_retire           <= r_retire + TAG_SZ'(1);
                r_valid[r_retire]  <= 1'b0;
            end
            if (w_resp_ok)
                r_valid[memresp_tag] <= 1'b1;
            if (w_resp_err)
                r_err <= 1'b1;
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + (TAG_SZ+1)'(1);
                2'b01:   r_count <= r_count - (TAG_SZ+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_resp_ok)
            r_data[memresp_tag] <= memresp_data;
    end
endmodule

// File: tb/tb_vuvmu_ctrl_vec_load_roq.sv
// Bench for the load reorder queue: directed scenarios with literal
// expectations plus randomized traffic against a queue-level model.
module tb_vuvmu_ctrl_vec_load_roq;
    localparam int N = 256;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   roq_deq_tag_bits;
    logic         roq_deq_tag_val;
    logic         deq_rdy = 1'b0;
    logic         mval = 1'b0;
    logic [7:0]   mtag = '0;
    logic [127:0] mdata = '0;
    logic [127:0] ldq_enq_bits;
    logic         ldq_enq_val;
    logic         ldq_rdy = 1'b0;
    logic [8:0]   roq_count;
    logic         roq_err;

    vuvmu_ctrl_vec_load_roq #(.TAG_SZ(8), .DATA_SZ(128)) dut (
        .clk(clk), .reset(reset),
        .roq_deq_tag_bits(roq_deq_tag_bits), .roq_deq_tag_val(roq_deq_tag_val),
        .roq_deq_tag_rdy(deq_rdy),
        .memresp_val(mval), .memresp_tag(mtag), .memresp_data(mdata),
        .ldq_enq_bits(ldq_enq_bits), .ldq_enq_val(ldq_enq_val), .ldq_enq_rdy(ldq_rdy),
        .roq_count(roq_count), .roq_err(roq_err)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Model: ring of N slots described by head index, occupancy and a
    // per-slot "data has arrived" flag.
    int           m_alloc = 0, m_retire = 0, m_count = 0;
    bit           m_err = 0;
    bit           m_valid [N];
    logic [127:0] m_data  [N];

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    task automatic model_reset();
        m_alloc = 0; m_retire = 0; m_count = 0; m_err = 0;
        for (int i = 0; i < N; i++) m_valid[i] = 0;
    endtask

    task automatic model_step();
        bit a, r;
        int off;
        a = (m_count < N) && deq_rdy;
        r = m_valid[m_retire] && ldq_rdy;
        if (mval) begin
            off = (int'(mtag) - m_retire + N) % N;
            if (off < m_count && !m_valid[mtag]) begin
                m_valid[mtag] = 1;
                m_data[mtag]  = mdata;
            end else m_err = 1;
        end
        if (r) begin
            m_valid[m_retire] = 0;
            m_retire = (m_retire + 1) % N;
        end
        if (a) m_alloc = (m_alloc + 1) % N;
        m_count = m_count + int'(a) - int'(r);
    endtask

    always @(negedge clk) begin
        chk("deq_tag_val", roq_deq_tag_val, m_count < N);
        chk("deq_tag_bits", roq_deq_tag_bits, m_alloc[7:0]);
        chk("ldq_val", ldq_enq_val, m_valid[m_retire]);
        if (m_valid[m_retire]) chk("ldq_bits", ldq_enq_bits, m_data[m_retire]);
        chk("count", roq_count, m_count[8:0]);
        chk("err", roq_err, m_err);
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic cyc(input bit dr, input bit mv, input int mt, input logic [127:0] md, input bit lr);
        deq_rdy = dr; mval = mv; mtag = mt[7:0]; mdata = md; ldq_rdy = lr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        deq_rdy = 0; mval = 0; ldq_rdy = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [127:0] d [4];
    logic [127:0] x;
    int outst [$];

    initial begin
        for (int i = 0; i < 4; i++) d[i] = rnd128();
        do_reset();
        chk("rst_deq_val", roq_deq_tag_val, 1'b1);
        chk("rst_deq_bits", roq_deq_tag_bits, 8'd0);
        chk("rst_ldq_val", ldq_enq_val, 1'b0);
        chk("rst_count", roq_count, 9'd0);
        chk("rst_err", roq_err, 1'b0);

        // In-order: each line appears one cycle after its response.
        repeat (3) cyc(1, 0, 0, '0, 0);
        chk("io_count3", roq_count, 9'd3);
        cyc(0, 1, 0, d[0], 1);
        chk("io_A", ldq_enq_bits, d[0]);
        cyc(0, 1, 1, d[1], 1);
        chk("io_B", ldq_enq_bits, d[1]);
        cyc(0, 1, 2, d[2], 1);
        chk("io_C", ldq_enq_bits, d[2]);
        cyc(0, 0, 0, '0, 1);
        chk("io_count0", roq_count, 9'd0);
        chk("io_val0", ldq_enq_val, 1'b0);

        // Out-of-order: head blocks until tag 0 arrives.
        do_reset();
        repeat (4) cyc(1, 0, 0, '0, 0);
        cyc(0, 1, 3, d[3], 1);
        cyc(0, 1, 1, d[1], 1);
        cyc(0, 1, 2, d[2], 1);
        chk("ooo_blocked", ldq_enq_val, 1'b0);
        cyc(0, 1, 0, d[0], 1);
        for (int i = 0; i < 4; i++) begin
            chk("ooo_order", ldq_enq_bits, d[i]);
            cyc(0, 0, 0, '0, 1);
        end
        chk("ooo_count0", roq_count, 9'd0);

        // Full and wrap.
        do_reset();
        repeat (N) cyc(1, 0, 0, '0, 0);
        chk("full_val", roq_deq_tag_val, 1'b0);
        chk("full_count", roq_count, 9'd256);
        cyc(1, 0, 0, '0, 0);
        cyc(0, 1, 0, d[0], 0);
        cyc(0, 0, 0, '0, 1);
        chk("wrap_val", roq_deq_tag_val, 1'b1);
        chk("wrap_bits", roq_deq_tag_bits, 8'd0);
        chk("wrap_count", roq_count, 9'd255);

        // Simultaneous allocate/retire and a held head.
        do_reset();
        repeat (5) cyc(1, 0, 0, '0, 0);
        cyc(0, 1, 0, d[1], 0);
        repeat (2) begin
            cyc(0, 0, 0, '0, 0);
            chk("hold_bits", ldq_enq_bits, d[1]);
        end
        cyc(1, 0, 0, '0, 1);
        chk("sim_count", roq_count, 9'd5);

        // Errors: unallocated tag, duplicate response.
        do_reset();
        cyc(0, 1, 7, d[2], 0);
        chk("err_unalloc", roq_err, 1'b1);
        repeat (3) cyc(0, 0, 0, '0, 0);
        chk("err_sticky", roq_err, 1'b1);
        do_reset();
        chk("err_cleared", roq_err, 1'b0);
        repeat (2) cyc(1, 0, 0, '0, 0);
        cyc(0, 1, 1, d[2], 0);
        cyc(0, 1, 1, d[3], 0);
        chk("err_dup", roq_err, 1'b1);
        cyc(0, 1, 0, d[0], 1);
        cyc(0, 0, 0, '0, 1);
        chk("dup_kept", ldq_enq_bits, d[2]);

        // Asynchronous reset mid-stream.
        do_reset();
        repeat (10) cyc(1, 0, 0, '0, 0);
        cyc(0, 1, 0, d[0], 0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_deq_val", roq_deq_tag_val, 1'b1);
        chk("arst_deq_bits", roq_deq_tag_bits, 8'd0);
        chk("arst_ldq_val", ldq_enq_val, 1'b0);
        chk("arst_count", roq_count, 9'd0);
        do_reset();
        cyc(0, 1, 3, d[1], 0);
        chk("arst_stale", roq_err, 1'b1);

        // Random legal traffic, then traffic with occasional bad tags.
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            for (int c = 0; c < 3000; c++) begin
                bit mv;
                int mt;
                outst.delete();
                for (int k = 0; k < m_count; k++)
                    if (!m_valid[(m_retire + k) % N]) outst.push_back((m_retire + k) % N);
                mv = 0; mt = 0;
                if (ph == 1 && $urandom_range(0, 19) == 0) begin
                    mv = 1; mt = $urandom_range(0, N - 1);
                end else if (outst.size() > 0 && $urandom_range(0, 9) < 6) begin
                    mv = 1; mt = outst[$urandom_range(0, outst.size() - 1)];
                end
                x = rnd128();
                cyc($urandom_range(0, 9) < (c % 600 < 300 ? 7 : 3), mv, mt, x,
                    $urandom_range(0, 9) < (c % 400 < 200 ? 8 : 2));
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
